irq_pend_ctrl: RTL

//  Upstream request-capture stage for the 8-input priority encoder path.
//  - Latches per-source interrupt requests into a pending register and applies an enable mask.
//  - Selects the highest-index enabled pending source (bit 7 highest, same convention as the encoder).
//  - Presents the selected source ID to the consumer via a req/ack handshake.
//  - Clears the selected pending bit on acknowledge.

---
 rtl/irq_pend_ctrl.sv | 102 ++++++++++
 1 files changed

// File: rtl/irq_pend_ctrl.sv
// Interrupt request capture: pending register, enable mask, highest-index grant via req/ack.
// Define IRQ_EDGE_DETECT_EN to capture rising edges of irq instead of levels.
module irq_pend_ctrl #(
    parameter int unsigned NSRC = 8,
    parameter int unsigned ID_W = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NSRC-1:0] irq,
    input  logic [NSRC-1:0] mask,
    input  logic            ack,
    output logic            req,
    output logic [ID_W-1:0] id,
    output logic            valid,
    output logic [NSRC-1:0] pend
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        GAP
    } state_t;

    state_t          state;
    logic [NSRC-1:0] hit;
    logic [NSRC-1:0] pend_next;
    logic [NSRC-1:0] cand;
    logic [ID_W-1:0] sel;

`ifdef IRQ_EDGE_DETECT_EN
    logic [NSRC-1:0] irq_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_d <= '0;
        end else begin
            irq_d <= irq;
        end
    end

    assign hit = irq & ~irq_d;
`else
    assign hit = irq;
`endif

    // Clearing the granted bit leaves only the same-cycle hit, so set wins over clear.
    always_comb begin
        pend_next = pend | hit;
        if (state == REQ && ack) begin
            pend_next[id] = hit[id];
        end
    end

    assign cand = pend & mask;

    // Later iterations override earlier ones, leaving the highest enabled index.
    always_comb begin
        sel = '0;
        for (int unsigned i = 0; i < NSRC; i++) begin
            if (cand[i]) begin
                sel = ID_W'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            req   <= 1'b0;
            id    <= '0;
            valid <= 1'b0;
            pend  <= '0;
        end else begin
            pend  <= pend_next;
            valid <= |(pend_next & mask);
            case (state)
                IDLE: begin
                    if (|cand) begin
                        id    <= sel;
                        req   <= 1'b1;
                        state <= REQ;
                    end
                end
                REQ: begin
                    if (ack) begin
                        req   <= 1'b0;
                        state <= GAP;
                    end
                end
                GAP: begin
                    req   <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    req   <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
